// File: rtl/flit_queue_bank.sv
// Bank of NPORTS x NVCS circular flit queues fed from one broadcast flit interface.
// Optional per-queue accept counters on a 16-bit shift chain when FQ_BANK_STATS_EN is defined.
module flit_queue_bank #(
  parameter int HADDR      = 0,
  parameter int ADDR_WIDTH = 8,
  parameter int NPORTS     = 4,
  parameter int NVCS       = 2,
  parameter int FLIT_WIDTH = 36,
  parameter int DEPTH      = 4,
  localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1,
  localparam int VW = (NVCS > 1) ? $clog2(NVCS) : 1,
  localparam int NQ = NPORTS * NVCS
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     measure,
  input  logic                     flit_in_valid,
  input  logic [FLIT_WIDTH-1:0]    flit_in,
  input  logic [ADDR_WIDTH+PW-1:0] nexthop_in,
  input  logic [VW-1:0]            flit_in_vc,
  output logic                     flit_ack,
  output logic [NQ*FLIT_WIDTH-1:0] flit_out,
  output logic [NQ-1:0]            flit_out_valid,
  input  logic [NQ-1:0]            dequeue,
  output logic                     error,
  output logic                     is_quiescent,
  input  logic                     stats_shift,
  input  logic [15:0]              stats_in,
  output logic [15:0]              stats_out
);
  localparam int AW = $clog2(DEPTH);
  localparam int QW = (NQ > 1) ? $clog2(NQ) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [PW:0] NPORTS_W = (PW+1)'(NPORTS);
  localparam logic [VW:0] NVCS_W   = (VW+1)'(NVCS);

  logic [FLIT_WIDTH-1:0] mem_q [NQ][DEPTH];
  logic [AW-1:0] rd_ptr_q [NQ];
  logic [AW-1:0] rd_ptr_d [NQ];
  logic [AW-1:0] wr_ptr_q [NQ];
  logic [AW-1:0] wr_ptr_d [NQ];
  logic [AW:0]   cnt_q [NQ];
  logic [AW:0]   cnt_d [NQ];
  logic          error_q, error_d;

  logic [ADDR_WIDTH-1:0] dst_addr;
  logic [PW-1:0] port;
  logic [VW-1:0] vc;
  logic          port_ok, vc_ok, addr_hit, match, port_err, deq_err, sel_full;
  logic [QW-1:0] q_sel;
  logic [NQ-1:0] enq, pop, empty;

  // Single-port / single-VC builds ignore the corresponding index field.
  assign dst_addr = nexthop_in[PW +: ADDR_WIDTH];
  assign port     = (NPORTS > 1) ? nexthop_in[PW-1:0] : '0;
  assign vc       = (NVCS > 1) ? flit_in_vc : '0;
  assign port_ok  = {1'b0, port} < NPORTS_W;
  assign vc_ok    = {1'b0, vc} < NVCS_W;
  assign addr_hit = dst_addr == ADDR_WIDTH'(HADDR);
  assign q_sel    = QW'(int'(port) * NVCS + int'(vc));
  assign match    = flit_in_valid & enable & addr_hit & port_ok & vc_ok;
  assign port_err = flit_in_valid & enable & addr_hit & ~port_ok;

  always_comb begin
    sel_full = 1'b0;
    for (int i = 0; i < NQ; i++) begin
      if (q_sel == QW'(i) && cnt_q[i] == FULL_CNT) sel_full = 1'b1;
    end
  end

  // Ack uses the pre-edge count, so a full queue refuses even while being popped.
  assign flit_ack = match & ~sel_full;

  always_comb begin
    enq            = '0;
    pop            = '0;
    empty          = '0;
    flit_out       = '0;
    flit_out_valid = '0;
    for (int i = 0; i < NQ; i++) begin
      empty[i]          = cnt_q[i] == '0;
      enq[i]            = flit_ack && (q_sel == QW'(i));
      pop[i]            = enable & dequeue[i] & ~empty[i];
      flit_out_valid[i] = ~empty[i];
      flit_out[i*FLIT_WIDTH +: FLIT_WIDTH] = mem_q[i][rd_ptr_q[i]];
    end
  end

  assign deq_err      = enable & |(dequeue & empty);
  assign error_d      = error_q | port_err | deq_err;
  assign error        = error_q;
  assign is_quiescent = &empty;

  always_comb begin
    for (int i = 0; i < NQ; i++) begin
      rd_ptr_d[i] = pop[i] ? rd_ptr_q[i] + 1'b1 : rd_ptr_q[i];
      wr_ptr_d[i] = enq[i] ? wr_ptr_q[i] + 1'b1 : wr_ptr_q[i];
      cnt_d[i]    = cnt_q[i];
      if (enq[i] && !pop[i]) cnt_d[i] = cnt_q[i] + 1'b1;
      else if (!enq[i] && pop[i]) cnt_d[i] = cnt_q[i] - 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      error_q <= 1'b0;
      for (int i = 0; i < NQ; i++) begin
        rd_ptr_q[i] <= '0;
        wr_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
    end else begin
      error_q <= error_d;
      for (int i = 0; i < NQ; i++) begin
        rd_ptr_q[i] <= rd_ptr_d[i];
        wr_ptr_q[i] <= wr_ptr_d[i];
        cnt_q[i]    <= cnt_d[i];
      end
    end
  end

  // Storage is not reset; contents are meaningless while a queue is empty.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NQ; i++) begin
      if (enq[i]) mem_q[i][wr_ptr_q[i]] <= flit_in;
    end
  end

`ifdef FQ_BANK_STATS_EN
  logic [15:0] stat_q [NQ];
  logic [15:0] stat_d [NQ];
  logic [15:0] chain_in [NQ];

  // Shift wins over a same-cycle increment; counters saturate at 0xFFFF.
  always_comb begin
    for (int i = 0; i < NQ; i++) begin
      chain_in[i] = (i == 0) ? stats_in : 16'h0000;
      stat_d[i]   = stat_q[i];
    end
    for (int i = 1; i < NQ; i++) chain_in[i] = stat_q[i-1];
    for (int i = 0; i < NQ; i++) begin
      if (stats_shift) stat_d[i] = chain_in[i];
      else if (measure && enq[i] && stat_q[i] != 16'hFFFF) stat_d[i] = stat_q[i] + 16'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NQ; i++) stat_q[i] <= '0;
    end else begin
      for (int i = 0; i < NQ; i++) stat_q[i] <= stat_d[i];
    end
  end

  assign stats_out = stat_q[NQ-1];
`else
  logic unused_stats;
  assign unused_stats = measure ^ stats_shift;
  assign stats_out    = stats_in;
`endif
endmodule
